// File: rtl/alarm_unit.sv
// alarm_unit: user-set BCD alarm (HH:MM), match detector, ring/snooze FSM and gated 500 Hz tone.
// Build option: define SNOOZE_LIMIT_EN to allow at most MAX_SNOOZE snoozes per alarm event.
module alarm_unit #(
  parameter int unsigned RING_SECS  = 60,
  parameter int unsigned SNOOZE_MIN = 5,
  parameter int unsigned BEEP_MS    = 500,
  parameter logic [7:0]  RESET_H    = 8'h07,
  parameter logic [7:0]  RESET_M    = 8'h00
`ifdef SNOOZE_LIMIT_EN
  ,
  parameter int unsigned MAX_SNOOZE = 3
`endif
) (
  input  logic       CP,
  input  logic       CR,
  input  logic       TICK,
  input  logic [7:0] Q_H,
  input  logic [7:0] Q_M,
  input  logic [7:0] Q_S,
  input  logic       AL_EN,
  input  logic       AL_SET,
  input  logic       AH_UP,
  input  logic       AM_UP,
  input  logic       STOP,
  input  logic       SNOOZE,
  output logic [7:0] A_H,
  output logic [7:0] A_M,
  output logic       RINGING,
  output logic       SNOOZED,
  output logic       AUDIO
);

  typedef enum logic [1:0] {S_IDLE, S_RING, S_SNOOZE} state_t;

  localparam logic [7:0]  RING_LIM    = 8'(RING_SECS);
  localparam logic [11:0] SNOOZE_LOAD = 12'(SNOOZE_MIN * 60);
  localparam logic [9:0]  BEEP_LIM    = 10'(BEEP_MS);

  state_t      state;
  state_t      state_nx;
  logic [7:0]  ring_cnt;
  logic [7:0]  ring_cnt_nx;
  logic [11:0] snooze_cnt;
  logic [11:0] snooze_cnt_nx;
  logic [9:0]  beep_cnt;
  logic        tone_en;
  logic        match;
  logic        snooze_ok;

  // BCD increment with wrap at 'top' (8'h23 for hours, 8'h59 for minutes).
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
    logic [7:0] r;
    if (v == top)
      r = 8'h00;
    else if (v[3:0] == 4'd9)
      r = {v[7:4] + 4'd1, 4'd0};
    else
      r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Alarm time register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge CP) begin
    if (!CR) begin
      A_H <= RESET_H;
      A_M <= RESET_M;
    end else if (AL_SET) begin
      if (AH_UP) A_H <= bcd_inc(A_H, 8'h23);
      if (AM_UP) A_M <= bcd_inc(A_M, 8'h59);
    end
  end

  assign match = TICK & AL_EN & ~AL_SET &
                 (Q_H == A_H) & (Q_M == A_M) & (Q_S == 8'h00);

  // ---------------------------------------------------------------------------
  // Snooze limiter
  // ---------------------------------------------------------------------------
`ifdef SNOOZE_LIMIT_EN
  localparam logic [7:0] SNOOZE_CAP = 8'(MAX_SNOOZE);

  logic [7:0] snooze_used;

  always_ff @(posedge CP) begin
    if (!CR)
      snooze_used <= '0;
    else if (state == S_IDLE && state_nx == S_RING)
      snooze_used <= '0;
    else if (state == S_RING && state_nx == S_SNOOZE)
      snooze_used <= snooze_used + 8'd1;
  end

  assign snooze_ok = (snooze_used < SNOOZE_CAP);
`else
  assign snooze_ok = 1'b1;
`endif

  // ---------------------------------------------------------------------------
  // Ring / snooze FSM
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nx      = state;
    ring_cnt_nx   = ring_cnt;
    snooze_cnt_nx = snooze_cnt;

    if (!AL_EN || AL_SET) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (match) begin
            state_nx      = S_RING;
            ring_cnt_nx   = '0;
            snooze_cnt_nx = '0;
          end
        end
        S_RING: begin
          if (STOP) begin
            state_nx = S_IDLE;
          end else if (SNOOZE && snooze_ok) begin
            state_nx      = S_SNOOZE;
            snooze_cnt_nx = SNOOZE_LOAD;
          end else if (TICK) begin
            ring_cnt_nx = ring_cnt + 8'd1;
            if (ring_cnt_nx == RING_LIM) state_nx = S_IDLE;
          end
        end
        S_SNOOZE: begin
          if (STOP) begin
            state_nx = S_IDLE;
          end else if (TICK) begin
            snooze_cnt_nx = snooze_cnt - 12'd1;
            if (snooze_cnt_nx == 12'd0) begin
              state_nx    = S_RING;
              ring_cnt_nx = '0;
            end
          end
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CP) begin
    if (!CR) begin
      state      <= S_IDLE;
      ring_cnt   <= '0;
      snooze_cnt <= '0;
    end else begin
      state      <= state_nx;
      ring_cnt   <= ring_cnt_nx;
      snooze_cnt <= snooze_cnt_nx;
    end
  end

  assign RINGING = (state == S_RING);
  assign SNOOZED = (state == S_SNOOZE);

  // ---------------------------------------------------------------------------
  // Tone generation
  // ---------------------------------------------------------------------------
  // beep_cnt measures CP cycles since the last second boundary.
  always_ff @(posedge CP) begin
    if (!CR || TICK)
      beep_cnt <= '0;
    else if (beep_cnt != BEEP_LIM)
      beep_cnt <= beep_cnt + 10'd1;
  end

  // The tone only starts on the first second boundary seen while already ringing.
  always_ff @(posedge CP) begin
    if (!CR)
      tone_en <= 1'b0;
    else
      tone_en <= (state == S_RING) && (state_nx == S_RING) && (tone_en || TICK);
  end

  // Looking at state_nx silences the output on the very edge that leaves RING.
  always_ff @(posedge CP) begin
    if (!CR)
      AUDIO <= 1'b0;
    else if (state_nx == S_RING && tone_en && beep_cnt < BEEP_LIM)
      AUDIO <= ~AUDIO;
    else
      AUDIO <= 1'b0;
  end

endmodule

// File: tb/tb_alarm_unit.sv
// tb_alarm_unit: randomized stimulus, behavioural reference model feeding a scoreboard queue,
// and an independent monitor that compares every DUT output cycle against the queue.
module tb_alarm_unit;

  localparam int RING_SECS  = 60;
  localparam int SNOOZE_MIN = 5;
  localparam int BEEP_MS    = 500;
  localparam int RST_H      = 7;
  localparam int RST_M      = 0;
`ifdef SNOOZE_LIMIT_EN
  localparam int MAX_SNOOZE = 3;
`endif

  logic       CP = 1'b0;
  logic       CR;
  logic       TICK;
  logic [7:0] Q_H, Q_M, Q_S;
  logic       AL_EN, AL_SET, AH_UP, AM_UP, STOP, SNOOZE;
  logic [7:0] A_H, A_M;
  logic       RINGING, SNOOZED, AUDIO;

  alarm_unit #(
    .RING_SECS (RING_SECS),
    .SNOOZE_MIN(SNOOZE_MIN),
    .BEEP_MS   (BEEP_MS),
    .RESET_H   (8'h07),
    .RESET_M   (8'h00)
`ifdef SNOOZE_LIMIT_EN
    ,
    .MAX_SNOOZE(MAX_SNOOZE)
`endif
  ) dut (
    .CP     (CP),
    .CR     (CR),
    .TICK   (TICK),
    .Q_H    (Q_H),
    .Q_M    (Q_M),
    .Q_S    (Q_S),
    .AL_EN  (AL_EN),
    .AL_SET (AL_SET),
    .AH_UP  (AH_UP),
    .AM_UP  (AM_UP),
    .STOP   (STOP),
    .SNOOZE (SNOOZE),
    .A_H    (A_H),
    .A_M    (A_M),
    .RINGING(RINGING),
    .SNOOZED(SNOOZED),
    .AUDIO  (AUDIO)
  );

  always #5 CP = ~CP;

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [7:0] ah;
    logic [7:0] am;
    logic       ring;
    logic       snz;
    logic       aud;
  } obs_t;

  typedef struct {
    obs_t  v;
    string tag;
    int    cyc;
  } exp_t;

  exp_t  sb[$];
  int    checks = 0;
  int    errors = 0;
  string phase  = "init";

  // ---------------------------------------------------------------------------
  // Reference model: decimal alarm time, ring/snooze bookkeeping in seconds,
  // tone window expressed as "cycles elapsed since the last second boundary".
  // ---------------------------------------------------------------------------
  localparam int M_IDLE = 0;
  localparam int M_RING = 1;
  localparam int M_SNZ  = 2;

  int m_mode = M_IDLE;
  int m_rung = 0;
  int m_snz_left = 0;
  int m_snz_used = 0;
  int m_al_h = RST_H;
  int m_al_m = RST_M;
  int cyc = 0;
  int last_tick = 0;
  bit m_armed = 1'b0;
  bit m_aud = 1'b0;

  int tod_h = 0, tod_m = 0, tod_s = 0;

  function automatic logic [7:0] bcd(input int v);
    return 8'(((v / 10) * 16) + (v % 10));
  endfunction

  task automatic model_edge(input bit rst, input bit tk, input bit en, input bit set,
                            input bit ah, input bit am, input bit stp, input bit sz);
    bit m_match;
    bit in_window;
    bit snz_ok;
    int nxt;
    cyc++;
    if (rst) begin
      m_mode = M_IDLE; m_rung = 0; m_snz_left = 0; m_snz_used = 0;
      m_al_h = RST_H; m_al_m = RST_M;
      m_armed = 1'b0; m_aud = 1'b0; last_tick = cyc;
      return;
    end
`ifdef SNOOZE_LIMIT_EN
    snz_ok = (m_snz_used < MAX_SNOOZE);
`else
    snz_ok = 1'b1;
`endif
    in_window = (cyc - last_tick) <= BEEP_MS;
    m_match = tk && en && !set && tod_h == m_al_h && tod_m == m_al_m && tod_s == 0;
    nxt = m_mode;
    if (!en || set) begin
      nxt = M_IDLE;
    end else if (m_mode == M_IDLE) begin
      if (m_match) begin nxt = M_RING; m_rung = 0; m_snz_used = 0; end
    end else if (m_mode == M_RING) begin
      if (stp) nxt = M_IDLE;
      else if (sz && snz_ok) begin
        nxt = M_SNZ; m_snz_left = SNOOZE_MIN * 60; m_snz_used++;
      end else if (tk) begin
        m_rung++;
        if (m_rung >= RING_SECS) nxt = M_IDLE;
      end
    end else begin
      if (stp) nxt = M_IDLE;
      else if (tk) begin
        m_snz_left--;
        if (m_snz_left == 0) begin nxt = M_RING; m_rung = 0; end
      end
    end
    m_aud = (nxt == M_RING && m_armed && in_window) ? !m_aud : 1'b0;
    m_armed = (m_mode == M_RING) && (nxt == M_RING) && (m_armed || tk);
    if (tk) last_tick = cyc;
    m_mode = nxt;
    if (set && ah) m_al_h = (m_al_h + 1) % 24;
    if (set && am) m_al_m = (m_al_m + 1) % 60;
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: pops one expectation per cycle, sampling on the falling edge.
  // ---------------------------------------------------------------------------
  initial begin : monitor
    exp_t e;
    obs_t got;
    forever begin
      @(negedge CP);
      if (sb.size() != 0) begin
        e   = sb.pop_front();
        got = {A_H, A_M, RINGING, SNOOZED, AUDIO};
        checks++;
        if (got !== e.v) begin
          errors++;
          $display("FAIL %s cyc %0d: got A_H=%h A_M=%h RINGING=%b SNOOZED=%b AUDIO=%b, expected A_H=%h A_M=%h RINGING=%b SNOOZED=%b AUDIO=%b",
                   e.tag, e.cyc, got.ah, got.am, got.ring, got.snz, got.aud,
                   e.v.ah, e.v.am, e.v.ring, e.v.snz, e.v.aud);
        end
      end
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached in phase %s, required completion", phase);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic advance_tod();
    tod_s++;
    if (tod_s == 60) begin tod_s = 0; tod_m++; end
    if (tod_m == 60) begin tod_m = 0; tod_h++; end
    if (tod_h == 24) tod_h = 0;
  endtask

  task automatic set_tod_secs(input int t);
    int w;
    w = ((t % 86400) + 86400) % 86400;
    tod_h = w / 3600; tod_m = (w / 60) % 60; tod_s = w % 60;
  endtask

  task automatic step(input bit tk = 1'b0, input bit ah = 1'b0, input bit am = 1'b0,
                      input bit stp = 1'b0, input bit sz = 1'b0);
    exp_t e;
    if (tk) advance_tod();
    TICK = tk; AH_UP = ah; AM_UP = am; STOP = stp; SNOOZE = sz;
    Q_H = bcd(tod_h); Q_M = bcd(tod_m); Q_S = bcd(tod_s);
    @(posedge CP);
    model_edge(!CR, tk, AL_EN, AL_SET, ah, am, stp, sz);
    e.v   = {bcd(m_al_h), bcd(m_al_m), m_mode == M_RING, m_mode == M_SNZ, m_aud};
    e.tag = phase;
    e.cyc = cyc;
    sb.push_back(e);
    #1;
    TICK = 1'b0; AH_UP = 1'b0; AM_UP = 1'b0; STOP = 1'b0; SNOOZE = 1'b0;
  endtask

  // One second: a TICK cycle followed by gap-1 quiet cycles.
  task automatic sec(input int gap, input bit sz = 1'b0, input bit stp = 1'b0);
    step(1'b1, 1'b0, 1'b0, stp, sz);
    repeat (gap - 1) step();
  endtask

  // Place the time of day just before the alarm minute and tick into the match.
  task automatic ring_now();
    set_tod_secs(m_al_h * 3600 + m_al_m * 60 - 1);
    step();
    step(1'b1);
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin : stimulus
    int h_left, m_left;
    bit ah, am;
    CR = 1'b0; TICK = 1'b0; AL_EN = 1'b0; AL_SET = 1'b0;
    AH_UP = 1'b0; AM_UP = 1'b0; STOP = 1'b0; SNOOZE = 1'b0;
    Q_H = 8'h00; Q_M = 8'h00; Q_S = 8'h00;
    @(posedge CP); #1;

    phase = "reset";
    repeat (3) step();
    CR = 1'b1;
    step();

    // Edit wraps both fields back to 00:00, with overlapping pulses
    phase = "edit_wrap";
    AL_SET = 1'b1;
    h_left = 17; m_left = 60;
    while (h_left > 0 || m_left > 0) begin
      ah = (h_left > 0) && ($urandom_range(0, 1) == 1);
      am = (m_left > 0) && ($urandom_range(0, 1) == 1);
      step(1'b0, ah, am);
      if (ah) h_left--;
      if (am) m_left--;
      if ($urandom_range(0, 3) == 0) step();
    end
    step();

    phase = "edit_ignored";
    AL_SET = 1'b0;
    repeat (4) step(1'b0, 1'b1, 1'b1);

    phase = "edit_restore";
    AL_SET = 1'b1;
    repeat (7) step(1'b0, 1'b1, 1'b0);
    AL_SET = 1'b0;
    step();

    // Ring with full-length seconds so the tone window opens and closes
    phase = "ring_tone";
    AL_EN = 1'b1;
    ring_now();
    repeat (999) step();
    repeat (4) sec(1000);

    phase = "ring_timeout";
    repeat (60) sec($urandom_range(2, 30));

    phase = "stop_no_retrigger";
    ring_now();
    repeat (3) sec(7);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (40) sec($urandom_range(2, 6));

    phase = "snooze";
    ring_now();
    repeat (5) sec($urandom_range(2, 8));
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (20) sec($urandom_range(2, 8));
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (285) sec($urandom_range(2, 8));
    repeat (3) sec(600);

    phase = "stop_and_snooze";
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (10) sec(3);

    phase = "al_en_drop";
    ring_now();
    sec(4);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (10) sec(3);
    AL_EN = 1'b0;
    step();
    AL_EN = 1'b1;
    repeat (10) sec(3);

    phase = "al_set_in_ring";
    ring_now();
    repeat (3) sec(5);
    AL_SET = 1'b1;
    step();
    AL_SET = 1'b0;
    repeat (5) sec(3);

    phase = "snooze_tick_same_cycle";
    ring_now();
    sec(3);
    sec(3, 1'b1);
    repeat (5) sec(3);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    phase = "snooze_repeat";
    ring_now();
    for (int k = 0; k < 4; k++) begin
      sec(2);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      repeat (SNOOZE_MIN * 60 + 1) sec(2);
    end
    repeat (5) sec(4);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Move the alarm so a mid-ring reset visibly restores it
    phase = "reset_mid_ring";
    AL_SET = 1'b1;
    repeat (3) step(1'b0, 1'b1, 1'b1);
    AL_SET = 1'b0;
    ring_now();
    repeat (999) step();
    sec(200);
    CR = 1'b0;
    step();
    CR = 1'b1;
    repeat (20) step();
    ring_now();
    sec(5);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    sec(5);
    CR = 1'b0;
    step();
    CR = 1'b1;
    repeat (10) sec(3);

    phase = "random_soak";
    for (int i = 0; i < 15000; i++) begin
      bit tk, sah, sam, sstp, ssz;
      CR = ($urandom_range(0, 999) != 0);
      if (AL_EN && $urandom_range(0, 599) == 0) AL_EN = 1'b0;
      else if (!AL_EN && $urandom_range(0, 49) == 0) AL_EN = 1'b1;
      if (!AL_SET && $urandom_range(0, 799) == 0) AL_SET = 1'b1;
      else if (AL_SET && $urandom_range(0, 19) == 0) AL_SET = 1'b0;
      if ($urandom_range(0, 299) == 0)
        set_tod_secs(m_al_h * 3600 + m_al_m * 60 - int'($urandom_range(1, 3)));
      tk   = ($urandom_range(0, 5) == 0);
      sah  = ($urandom_range(0, 3) == 0);
      sam  = ($urandom_range(0, 3) == 0);
      sstp = ($urandom_range(0, 199) == 0);
      ssz  = ($urandom_range(0, 59) == 0);
      step(tk, sah, sam, sstp, ssz);
    end
    CR = 1'b1;

    phase = "drain";
    for (int i = 0; i < 8 && sb.size() != 0; i++) @(negedge CP);
    #1;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left uncompared, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
